// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502 control sequencer: state encoding,
// address/ALU operand selects, group-01 operation and addressing-mode codes.
package cpu6502_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_OPR_LO = 3'd1,
        ST_OPR_HI = 3'd2,
        ST_INDEX  = 3'd3,
        ST_EXEC   = 3'd4
    } state_t;

    // Address bus source
    localparam logic [1:0] ADDR_PC  = 2'b00;
    localparam logic [1:0] ADDR_ZP  = 2'b01;
    localparam logic [1:0] ADDR_ABS = 2'b10;

    // ALU A-operand source
    localparam logic [1:0] ALU_A = 2'b00;
    localparam logic [1:0] ALU_X = 2'b01;
    localparam logic [1:0] ALU_Y = 2'b10;

    // aaa field of group-01 opcodes
    localparam logic [2:0] OP_ORA = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_EOR = 3'b010;
    localparam logic [2:0] OP_ADC = 3'b011;
    localparam logic [2:0] OP_STA = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_SBC = 3'b111;

    // bbb field of group-01 opcodes
    localparam logic [2:0] MODE_IND_X = 3'b000;  // (zp,X): not supported
    localparam logic [2:0] MODE_ZP    = 3'b001;
    localparam logic [2:0] MODE_IMM   = 3'b010;
    localparam logic [2:0] MODE_ABS   = 3'b011;
    localparam logic [2:0] MODE_IND_Y = 3'b100;  // (zp),Y: not supported
    localparam logic [2:0] MODE_ZP_X  = 3'b101;
    localparam logic [2:0] MODE_ABS_Y = 3'b110;
    localparam logic [2:0] MODE_ABS_X = 3'b111;

    // STA and CMP leave the accumulator untouched
    function automatic logic writes_a(input logic [2:0] op);
        return (op != OP_STA) && (op != OP_CMP);
    endfunction

    // Only STA leaves the flags untouched
    function automatic logic writes_flags(input logic [2:0] op);
        return (op != OP_STA);
    endfunction

endpackage

// File: rtl/cpu_sequencer_decoder.sv
// Combinational group-01 opcode decoder: splits the opcode into its
// operation and addressing-mode fields and flags the supported subset.
module opcode_decoder
    import cpu6502_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [2:0] mode,
    output logic [2:0] op,
    output logic       legal
);

    assign op   = opcode[7:5];
    assign mode = opcode[4:2];

    // Indirect modes and STA immediate have no sequence here
    assign legal = (opcode[1:0] == 2'b01)
                 && (mode != MODE_IND_X)
                 && (mode != MODE_IND_Y)
                 && !((op == OP_STA) && (mode == MODE_IMM));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the group-01 instructions of the 6502
// core. Mealy outputs from state, latched opcode and mem_ready; a wait-state
// counter aborts any access that stalls longer than MAX_WAIT cycles.
module cpu_sequencer
    import cpu6502_pkg::*;
#(
    parameter int STALL_EN = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_ready,
    input  logic [7:0] data_in,
    output logic       sync,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       adl_load,
    output logic       adh_load,
    output logic [1:0] addr_sel,
    output logic       index_add,
    output logic       index_sel,
    output logic       zp_wrap,
    output logic       a_load,
    output logic       flag_load,
    output logic       mem_we,
    output logic [1:0] alu_sel,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic       bus_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state, state_nxt;
    logic [7:0]        opcode_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic       rdy;
    logic       stalled;
    logic [7:0] dec_in;
    logic [2:0] mode;
    logic [2:0] op;
    logic       legal;

    // With stalling disabled every access completes in one cycle
    assign rdy     = (STALL_EN == 0) || mem_ready;
    // INDEX is internal and never waits on memory
    assign stalled = (state != ST_INDEX) && !rdy;
    // The incoming opcode is decoded in FETCH, the latched one afterwards
    assign dec_in  = (state == ST_FETCH) ? data_in : opcode_q;

    opcode_decoder u_dec (
        .opcode (dec_in),
        .mode   (mode),
        .op     (op),
        .legal  (legal)
    );

    // Next-state and strobe decode; everything held low while in reset
    always_comb begin
        state_nxt   = state;
        sync        = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        adl_load    = 1'b0;
        adh_load    = 1'b0;
        addr_sel    = ADDR_PC;
        index_add   = 1'b0;
        index_sel   = 1'b0;
        zp_wrap     = 1'b0;
        a_load      = 1'b0;
        flag_load   = 1'b0;
        mem_we      = 1'b0;
        alu_sel     = ALU_A;
        alu_op      = 3'b000;
        illegal     = 1'b0;
        bus_timeout = 1'b0;
        if (rst) begin
            alu_op = opcode_q[7:5];
            case (state)
                ST_FETCH: begin
                    sync = 1'b1;
                    if (rdy) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                        if (legal) state_nxt = ST_OPR_LO;
                        else       illegal   = 1'b1;
                    end
                end
                ST_OPR_LO: begin
                    if (rdy) begin
                        pc_inc = 1'b1;
                        case (mode)
                            MODE_IMM: begin
                                a_load    = writes_a(op);
                                flag_load = writes_flags(op);
                                state_nxt = ST_FETCH;
                            end
                            MODE_ZP: begin
                                adl_load  = 1'b1;
                                state_nxt = ST_EXEC;
                            end
                            MODE_ZP_X: begin
                                adl_load  = 1'b1;
                                state_nxt = ST_INDEX;
                            end
                            default: begin
                                adl_load  = 1'b1;
                                state_nxt = ST_OPR_HI;
                            end
                        endcase
                    end
                end
                ST_OPR_HI: begin
                    if (rdy) begin
                        adh_load  = 1'b1;
                        pc_inc    = 1'b1;
                        state_nxt = (mode == MODE_ABS) ? ST_EXEC : ST_INDEX;
                    end
                end
                ST_INDEX: begin
                    index_add = 1'b1;
                    zp_wrap   = (mode == MODE_ZP_X);
                    index_sel = (mode == MODE_ABS_Y);
                    state_nxt = ST_EXEC;
                end
                ST_EXEC: begin
                    addr_sel = ((mode == MODE_ZP) || (mode == MODE_ZP_X)) ? ADDR_ZP : ADDR_ABS;
                    if (op == OP_STA) begin
                        mem_we = 1'b1;
                    end else if (rdy) begin
                        a_load    = writes_a(op);
                        flag_load = writes_flags(op);
                    end
                    if (rdy) state_nxt = ST_FETCH;
                end
                default: state_nxt = ST_FETCH;
            endcase
            // An expired wait abandons the instruction, including any write
            if (stalled && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
                bus_timeout = 1'b1;
                mem_we      = 1'b0;
                state_nxt   = ST_FETCH;
            end
        end
    end

    // State, opcode latch and wait-state counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FETCH;
            opcode_q <= 8'h00;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (ir_load) opcode_q <= data_in;
            if (stalled && !bus_timeout) wait_cnt <= wait_cnt + 1'b1;
            else                         wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed instructions followed by
// random opcodes and random wait states, compared cycle by cycle against an
// instruction-level model that lists the bus cycles each opcode needs.
module tb_cpu_sequencer;

    localparam int MW = 15;

    typedef struct packed {
        logic       sync;
        logic       ir_load;
        logic       pc_inc;
        logic       adl_load;
        logic       adh_load;
        logic [1:0] addr_sel;
        logic       index_add;
        logic       index_sel;
        logic       zp_wrap;
        logic       a_load;
        logic       flag_load;
        logic       mem_we;
        logic [1:0] alu_sel;
        logic [2:0] alu_op;
        logic       illegal;
        logic       bus_timeout;
    } vec_t;

    typedef struct {
        vec_t v;
        bit   stallable;
    } phase_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_ready = 1'b0;
    logic [7:0] data_in = 8'h00;
    wire [19:0] ov [2];

    int         sel = 0;          // 0: STALL_EN=1 instance, 1: STALL_EN=0 instance
    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] cur_aaa = 3'b000; // aaa of the opcode most recently fetched

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cpu_sequencer #(.STALL_EN(g == 0 ? 1 : 0), .MAX_WAIT(MW)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .mem_ready   (mem_ready),
            .data_in     (data_in),
            .sync        (ov[g][19]),
            .ir_load     (ov[g][18]),
            .pc_inc      (ov[g][17]),
            .adl_load    (ov[g][16]),
            .adh_load    (ov[g][15]),
            .addr_sel    (ov[g][14:13]),
            .index_add   (ov[g][12]),
            .index_sel   (ov[g][11]),
            .zp_wrap     (ov[g][10]),
            .a_load      (ov[g][9]),
            .flag_load   (ov[g][8]),
            .mem_we      (ov[g][7]),
            .alu_sel     (ov[g][6:5]),
            .alu_op      (ov[g][4:2]),
            .illegal     (ov[g][1]),
            .bus_timeout (ov[g][0])
        );
    end

    task automatic check(input vec_t exp, input string tag);
        vec_t obs;
        obs = ov[sel];
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check mid-cycle, then advance past the edge
    task automatic apply(input logic rdy, input logic [7:0] din, input vec_t exp, input string tag);
        mem_ready = rdy;
        data_in   = din;
        #2;
        check(exp, tag);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t base(input logic [2:0] aaa);
        vec_t v;
        v = '0;
        v.alu_op = aaa;
        return v;
    endfunction

    // Runs one instruction. stall_pct: random wait-state probability;
    // hold_phase/hold_len: force mem_ready=0 for the first hold_len cycles of
    // that phase; rst_phase: pull reset in the middle of that phase.
    task automatic instr(input logic [7:0] op, input int stall_pct, input int hold_phase,
                         input int hold_len, input int rst_phase, input string tag);
        logic [2:0] aaa;
        logic [2:0] bbb;
        bit         legal, wa, wf, zpg;
        phase_t     ph[$];
        phase_t     p;
        aaa   = op[7:5];
        bbb   = op[4:2];
        legal = (op[1:0] == 2'b01) && (bbb != 3'd0) && (bbb != 3'd4) && (op != 8'h89);
        wa    = (aaa != 3'd4) && (aaa != 3'd6);
        wf    = (aaa != 3'd4);
        zpg   = (bbb == 3'd1) || (bbb == 3'd5);

        p.stallable = 1'b1;
        p.v = base(cur_aaa);
        p.v.sync = 1'b1; p.v.ir_load = 1'b1; p.v.pc_inc = 1'b1; p.v.illegal = !legal;
        ph.push_back(p);
        if (legal) begin
            if (bbb == 3'd2) begin
                p.v = base(aaa);
                p.v.pc_inc = 1'b1; p.v.a_load = wa; p.v.flag_load = wf;
                ph.push_back(p);
            end else begin
                p.v = base(aaa);
                p.v.pc_inc = 1'b1; p.v.adl_load = 1'b1;
                ph.push_back(p);
                if (!zpg) begin
                    p.v = base(aaa);
                    p.v.pc_inc = 1'b1; p.v.adh_load = 1'b1;
                    ph.push_back(p);
                end
                if ((bbb != 3'd1) && (bbb != 3'd3)) begin
                    p.v = base(aaa);
                    p.v.index_add = 1'b1; p.v.zp_wrap = (bbb == 3'd5); p.v.index_sel = (bbb == 3'd6);
                    p.stallable = 1'b0;
                    ph.push_back(p);
                    p.stallable = 1'b1;
                end
                p.v = base(aaa);
                p.v.addr_sel = zpg ? 2'b01 : 2'b10;
                if (aaa == 3'd4) p.v.mem_we = 1'b1;
                else begin p.v.a_load = wa; p.v.flag_load = wf; end
                ph.push_back(p);
            end
        end

        for (int i = 0; i < ph.size(); i++) begin
            int waits;
            waits = 0;
            forever begin
                logic       rdy, eff;
                logic [7:0] din;
                vec_t       e;
                if (i == hold_phase && waits < hold_len) rdy = 1'b0;
                else rdy = (int'($urandom_range(99)) >= stall_pct);
                if (i == rst_phase) rdy = 1'b0;
                eff = rdy || (sel == 1);
                din = (i == 0 && eff) ? op : 8'($urandom);
                e = ph[i].v;
                if (eff || !ph[i].stallable) begin
                    apply(rdy, din, e, $sformatf("%s.p%0d", tag, i));
                    if (i == 0) cur_aaa = aaa;
                    break;
                end
                e.ir_load = 1'b0; e.pc_inc = 1'b0; e.adl_load = 1'b0; e.adh_load = 1'b0;
                e.a_load = 1'b0; e.flag_load = 1'b0; e.illegal = 1'b0;
                if (i == rst_phase) begin
                    mem_ready = rdy;
                    data_in   = din;
                    #2;
                    check(e, {tag, ".pre_rst"});
                    rst = 1'b0;
                    #1;
                    check('0, {tag, ".in_rst"});
                    @(posedge clk);
                    #1;
                    rst = 1'b1;
                    cur_aaa = 3'b000;
                    return;
                end
                if (waits == MW) begin
                    e.bus_timeout = 1'b1;
                    e.mem_we      = 1'b0;
                    apply(rdy, din, e, $sformatf("%s.p%0d.timeout", tag, i));
                    return;
                end
                apply(rdy, din, e, $sformatf("%s.p%0d.stall%0d", tag, i, waits));
                waits++;
            end
        end
    endtask

    task automatic reset_both();
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        data_in   = 8'hA9;
        #2;
        check('0, "reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        cur_aaa = 3'b000;
    endtask

    initial begin
        logic [7:0] rop;

        reset_both();

        instr(8'hA9, 0, -1, 0, -1, "lda_imm");
        instr(8'h85, 0, -1, 0, -1, "sta_zp");
        instr(8'h7D, 0, -1, 0, -1, "adc_absx");
        instr(8'h79, 0, -1, 0, -1, "adc_absy");
        instr(8'h75, 0, -1, 0, -1, "adc_zpx");
        instr(8'h89, 0, -1, 0, -1, "sta_imm_bad");
        instr(8'h61, 0, -1, 0, -1, "indx_bad");
        instr(8'hCD, 0, -1, 0, -1, "cmp_abs");
        instr(8'hA5, 0, 2, 3, -1, "lda_zp_wait3");
        instr(8'hA5, 0, 2, MW + 1, -1, "lda_zp_timeout");
        instr(8'h09, 0, 0, MW + 1, -1, "fetch_timeout");
        instr(8'h85, 0, -1, 0, 2, "sta_rst");
        instr(8'hE9, 0, -1, 0, -1, "sbc_imm_after_rst");

        for (int n = 0; n < 250; n++) begin
            rop = 8'($urandom);
            if ($urandom_range(4) != 0) rop[1:0] = 2'b01;
            instr(rop, 20, -1, 0, -1, $sformatf("rnd%0d_%h", n, rop));
        end

        sel = 1;
        reset_both();
        instr(8'hA5, 0, 2, 3, -1, "ns_lda_zp_hold");
        instr(8'h7D, 0, 1, MW + 1, -1, "ns_adc_absx_hold");
        for (int n = 0; n < 100; n++) begin
            rop = 8'($urandom);
            if ($urandom_range(4) != 0) rop[1:0] = 2'b01;
            instr(rop, 50, -1, 0, -1, $sformatf("ns_rnd%0d_%h", n, rop));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
